// File: rtl/external_io_test.sv
// external_io_test: DIP switches to LEDs through a 2-flop synchronizer and per-bit debounce filter
module external_io_test #(
   parameter int STABLE_CYCLES = 2,
   parameter bit LED_INVERT    = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] trainer_dip,
   output logic [7:0] led
);
   localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
   logic [7:0]         r_s1;
   logic [7:0]         r_s2;
   logic [7:0]         r_stable;
   logic [7:0][CW-1:0] r_cnt;
   // two-flop synchronizer; metastability is confined to r_s1
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= trainer_dip;
         r_s2 <= r_s1;
      end
   end
   // independent per-bit filter: adopt s2 only after it disagrees for STABLE_CYCLES edges
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stable <= '0;
         r_cnt    <= '0;
      end else begin
         for (int b = 0; b < 8; b++) begin
            if (r_s2[b] == r_stable[b]) begin
               r_cnt[b] <= '0;
            end else if (r_cnt[b] == LAST) begin
               r_stable[b] <= r_s2[b];
               r_cnt[b]    <= '0;
            end else begin
               r_cnt[b] <= r_cnt[b] + CW'(1);
            end
         end
      end
   end
   assign led = r_stable ^ {8{LED_INVERT}};
endmodule

// File: tb/tb_external_io_test.sv
// tb_external_io_test: table vectors, corner sequences and random stimulus against a window-based model
module tb_external_io_test;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] trainer_dip = 8'h00;
   logic [7:0] led0, led1, led2;
   int         checks = 0;
   int         errors = 0;
   bit         mon_en = 1'b0;

   always #10 clk = ~clk;

   external_io_test u0 (.clk(clk), .rst(rst), .trainer_dip(trainer_dip), .led(led0));
   external_io_test #(.STABLE_CYCLES(2), .LED_INVERT(1'b1)) u1 (.clk(clk), .rst(rst), .trainer_dip(trainer_dip), .led(led1));
   external_io_test #(.STABLE_CYCLES(1), .LED_INVERT(1'b0)) u2 (.clk(clk), .rst(rst), .trainer_dip(trainer_dip), .led(led2));

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input logic [7:0] d, input logic r);
      trainer_dip = d;
      rst = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reference: a bit adopts the synchronized value once the last N
   // synchronized samples all disagree with the currently shown value.
   logic [7:0] m_s1, m_s2, m_st2, m_st1, f2, f1;
   logic [7:0] w2[$];
   logic [7:0] w1[$];
   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_s1 = 8'h00; m_s2 = 8'h00; m_st2 = 8'h00; m_st1 = 8'h00;
         w2 = '{8'h00, 8'h00};
         w1 = '{8'h00};
      end else begin
         w2.push_back(m_s2); void'(w2.pop_front());
         w1.push_back(m_s2); void'(w1.pop_front());
         f2 = 8'hFF; foreach (w2[j]) f2 &= w2[j] ^ m_st2;
         f1 = 8'hFF; foreach (w1[j]) f1 &= w1[j] ^ m_st1;
         m_st2 ^= f2;
         m_st1 ^= f1;
         m_s2 = m_s1;
         m_s1 = trainer_dip;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("model_sc2", led0, m_st2);
         chk("model_inv", led1, ~m_st2);
         chk("model_sc1", led2, m_st1);
      end
   end

   typedef struct {
      logic [7:0] dip;
      logic       r;
      int         n;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[$];

   logic [7:0] d;
   int         h;
   logic       rr;

   initial begin
      tbl = '{
         '{8'hFF, 1'b1, 2, 8'h00},
         '{8'hFF, 1'b0, 3, 8'h00}, '{8'hFF, 1'b0, 1, 8'hFF},
         '{8'h00, 1'b0, 3, 8'hFF}, '{8'h00, 1'b0, 1, 8'h00},
         '{8'h01, 1'b0, 3, 8'h00}, '{8'h01, 1'b0, 1, 8'h01},
         '{8'h0F, 1'b0, 3, 8'h01}, '{8'h0F, 1'b0, 1, 8'h0F},
         '{8'h8F, 1'b0, 3, 8'h0F}, '{8'h8F, 1'b0, 1, 8'h8F},
         '{8'h0F, 1'b0, 3, 8'h8F}, '{8'h0F, 1'b0, 1, 8'h0F},
         '{8'h8F, 1'b0, 1, 8'h0F}, '{8'h0F, 1'b0, 5, 8'h0F},
         '{8'h8F, 1'b0, 2, 8'h0F}, '{8'h0F, 1'b0, 1, 8'h0F},
         '{8'h0F, 1'b0, 1, 8'h8F}, '{8'h0F, 1'b0, 1, 8'h8F},
         '{8'h0F, 1'b0, 1, 8'h0F},
         '{8'h0E, 1'b0, 1, 8'h0F}, '{8'h0C, 1'b0, 2, 8'h0F},
         '{8'h0C, 1'b0, 1, 8'h0E}, '{8'h0C, 1'b0, 1, 8'h0C},
         '{8'h00, 1'b0, 3, 8'h0C}, '{8'h00, 1'b0, 1, 8'h00},
         '{8'hAA, 1'b0, 2, 8'h00}, '{8'hAA, 1'b1, 1, 8'h00},
         '{8'hAA, 1'b0, 3, 8'h00}, '{8'hAA, 1'b0, 1, 8'hAA}
      };
      tick(8'hFF, 1'b1);
      mon_en = 1'b1;
      chk("reset_led", led0, 8'h00);
      chk("reset_led_inv", led1, 8'hFF);
      foreach (tbl[v]) begin
         repeat (tbl[v].n) tick(tbl[v].dip, tbl[v].r);
         chk($sformatf("vec%0d", v), led0, tbl[v].exp);
         chk($sformatf("vec%0d_inv", v), led1, ~tbl[v].exp);
      end
      tick(8'h00, 1'b1);
      tick(8'h33, 1'b0);
      chk("sc1_step_k", led2, 8'h00);
      tick(8'h33, 1'b0);
      chk("sc1_step_k1", led2, 8'h00);
      tick(8'h33, 1'b0);
      chk("sc1_step_k2", led2, 8'h33);
      tick(8'h3B, 1'b0);
      chk("sc1_pulse_k", led2, 8'h33);
      tick(8'h33, 1'b0);
      chk("sc1_pulse_k1", led2, 8'h33);
      tick(8'h33, 1'b0);
      chk("sc1_pulse_k2", led2, 8'h3B);
      tick(8'h33, 1'b0);
      chk("sc1_pulse_end", led2, 8'h33);
      tick(8'h33, 1'b0);
      chk("sc2_pulse_rejected", led0, 8'h33);
      d = 8'h33;
      for (int c = 0; c < 400; c++) begin
         d ^= 8'($urandom) & 8'($urandom);
         h = $urandom_range(1, 4);
         rr = ($urandom_range(0, 40) == 0);
         tick(d, rr);
         repeat (h - 1) tick(d, 1'b0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
